// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with round-robin or fixed-priority arbitration,
// a registered single-stage output and optional per-packet grant locking.
module rr_stream_mux #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN),
    parameter int unsigned RR    = 1,
    parameter int unsigned LOCK  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN-1:0]         in_last,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } lock_state_t;

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic [SEL_W-1:0]   r_lock_ch;
    logic [SEL_W-1:0]   w_lock_ch_nxt;
    logic               w_locked;

    logic [SEL_W-1:0]   r_ptr;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic               r_out_last;

    logic               w_load;
    logic [SEL_W-1:0]   w_rr_grant;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_fp_grant;
    logic               w_fp_found;
    logic [SEL_W-1:0]   w_grant;
    logic               w_grant_valid;
    logic               w_accept;
    logic [WIDTH-1:0]   w_data;
    logic               w_last;

    assign w_load = !r_out_valid || out_ready;

    // Round-robin search in two passes: channels above the pointer first, then wrap to 0..ptr.
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!w_rr_found && in_valid[i] && (i > 32'(r_ptr))) begin
                w_rr_found = 1'b1;
                w_rr_grant = i[SEL_W-1:0];
            end
        end
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!w_rr_found && in_valid[i] && (i <= 32'(r_ptr))) begin
                w_rr_found = 1'b1;
                w_rr_grant = i[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        w_fp_grant = '0;
        w_fp_found = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!w_fp_found && in_valid[i]) begin
                w_fp_found = 1'b1;
                w_fp_grant = i[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        if (w_locked) begin
            w_grant = r_lock_ch;
        end else if (RR != 0) begin
            w_grant = w_rr_grant;
        end else begin
            w_grant = w_fp_grant;
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_data        = '0;
        w_last        = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (w_grant == i[SEL_W-1:0]) begin
                w_grant_valid = in_valid[i];
                w_data        = in_data[i*WIDTH +: WIDTH];
                w_last        = in_last[i];
            end
        end
    end

    assign w_accept = w_load && w_grant_valid;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (w_accept && (w_grant == i[SEL_W-1:0])) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    // Lock FSM: next state; while locked the grant is the locked channel, so any accept comes from it
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        if ((LOCK != 0) && w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_last) begin
                        w_state_nxt   = S_LOCKED;
                        w_lock_ch_nxt = w_grant;
                    end
                end
                S_LOCKED: begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Lock FSM: outputs
    always_comb begin
        w_locked = (LOCK != 0) && (r_state == S_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SEL_W'(N_IN - 1);
        end else if ((RR != 0) && w_accept) begin
            r_ptr <= w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_data;
                r_out_sel  <= w_grant;
                r_out_last <= w_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a round-robin/locking instance and a fixed-priority instance share
// stimulus; in_ready is checked against table values, output words against a scoreboard queue.
module tb_rr_stream_mux;

    typedef struct {
        bit          rb;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [15:0] d;
        bit          ordy;
        logic [3:0]  ea;
        logic [3:0]  eb;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [1:0] sel;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_last = '0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  ir [2];
    logic        ov [2];
    logic [3:0]  od [2];
    logic [1:0]  os [2];
    logic        ol [2];

    int   n_checks = 0;
    int   n_pass = 0;
    bit   ev [2];
    exp_t q0 [$];
    exp_t q1 [$];
    vec_t vecs [$];

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(4), .N_IN(4), .RR(1), .LOCK(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_sel(os[0]), .out_last(ol[0])
    );

    rr_stream_mux #(.WIDTH(4), .N_IN(4), .RR(0), .LOCK(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_sel(os[1]), .out_last(ol[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    endtask

    task automatic check_dut(input int d, input logic [3:0] exp_ir, input vec_t v);
        exp_t e;
        bit   have;
        int   idx;
        chk("in_ready", d, 32'(ir[d]), 32'(exp_ir));
        chk("out_valid", d, 32'(ov[d]), 32'(ev[d]));
        if (ev[d] && v.ordy) begin
            have = 0;
            if (d == 0) begin
                if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            end else begin
                if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            end
            if (have) begin
                chk("out_data", d, 32'(od[d]), 32'(e.data));
                chk("out_sel", d, 32'(os[d]), 32'(e.sel));
                chk("out_last", d, 32'(ol[d]), 32'(e.last));
            end else begin
                n_checks++;
                $display("FAIL scoreboard dut%0d: got word with no expected entry, expected none", d);
            end
        end
        if (exp_ir != 0) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (exp_ir[k]) idx = k;
            e.data = v.d[idx*4 +: 4];
            e.sel  = 2'(idx);
            e.last = v.l[idx];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            ev[d] = 1'b1;
        end else if (!ev[d] || v.ordy) begin
            ev[d] = 1'b0;
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        in_valid  = v.v;
        in_last   = v.l;
        in_data   = v.d;
        out_ready = v.ordy;
        @(negedge clk);
        check_dut(0, v.ea, v);
        check_dut(1, v.eb, v);
    endtask

    // Reset is raised between clock edges so clearing must not wait for a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 32'(ov[d]), 32'd0);
            chk("rst_data", d, 32'(od[d]), 32'd0);
            chk("rst_sel", d, 32'(os[d]), 32'd0);
            chk("rst_last", d, 32'(ol[d]), 32'd0);
        end
        q0.delete();
        q1.delete();
        ev[0] = 1'b0;
        ev[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // rb, valid, last, data, out_ready, exp in_ready (rr+lock), exp in_ready (fixed)
        vecs.push_back(vec_t'{0, 4'b0100, 4'hF, 16'h9A53, 1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{0, 4'b0000, 4'hF, 16'h9753, 1, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{1, 4'b1111, 4'hF, 16'h9753, 1, 4'b0001, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b0010, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b0100, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b1000, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b0001, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b0010, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0100, 4'hF, 16'h9753, 1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 0, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 0, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 0, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b1111, 4'hF, 16'h9753, 1, 4'b1000, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0000, 4'hF, 16'h9753, 1, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b0000, 4'hF, 16'h9753, 1, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b1010, 4'hF, 16'h9753, 1, 4'b0010, 4'b0010});
        vecs.push_back(vec_t'{0, 4'b1010, 4'hF, 16'h9753, 1, 4'b1000, 4'b0010});
        vecs.push_back(vec_t'{0, 4'b1010, 4'hF, 16'h9753, 1, 4'b0010, 4'b0010});
        vecs.push_back(vec_t'{0, 4'b0000, 4'hF, 16'h9753, 1, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{0, 4'b0101, 4'h0, 16'h9753, 1, 4'b0100, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0001, 4'h0, 16'h9753, 1, 4'b0000, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0101, 4'h0, 16'h9B53, 1, 4'b0100, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0101, 4'h4, 16'h9C53, 1, 4'b0100, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0001, 4'h0, 16'h9753, 1, 4'b0001, 4'b0001});
        vecs.push_back(vec_t'{0, 4'b0000, 4'h0, 16'h9753, 1, 4'b0000, 4'b0000});

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].rb) do_reset();
            step(vecs[i]);
        end

        // Reset while the output is full and the lock is held on channel 2.
        do_reset();
        step(vec_t'{0, 4'b0100, 4'h0, 16'h9753, 1, 4'b0100, 4'b0100});
        step(vec_t'{0, 4'b0000, 4'h0, 16'h9753, 0, 4'b0000, 4'b0000});
        do_reset();
        step(vec_t'{0, 4'b1001, 4'h0, 16'h9D5E, 1, 4'b0001, 4'b0001});
        step(vec_t'{0, 4'b0000, 4'h0, 16'h9753, 1, 4'b0000, 4'b0000});
        step(vec_t'{0, 4'b0000, 4'h0, 16'h9753, 1, 4'b0000, 4'b0000});

        chk("q_empty", 0, 32'(q0.size()), 32'd0);
        chk("q_empty", 1, 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
